ctrl_pipe: RTL and testbench

- Consumer end of the main control decoder's 8-bit control bundle (EX/M/WB fields).
- Carries the bundle, plus register addresses, through the ID/EX, EX/MEM and MEM/WB pipeline registers, and fans the fields out to each stage's datapath.
- Contains the load-use hazard detector, which drives a stall and inserts bubbles, and the EX-stage forwarding selector.
- Sits between the control decoder / IF-ID register and the EX/MEM/WB datapath.

---
 rtl/ctrl_pipe_pkg.sv | 32 +++
 rtl/fwd_unit.sv | 63 ++++++
 rtl/ctrl_pipe.sv | 161 ++++++++++++++++
 tb/tb_ctrl_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pipe_pkg
//  Description : Shared constants for the control pipeline. This covers the
//                control bundle width, the register address width, the bit
//                position of every field in the 8-bit decoder bundle, and the
//                select encodings for the EX-stage forwarding mux.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pipe_pkg;

    // Bundle and register address widths
    localparam int c_CTRL_W = 8;
    localparam int c_RA_W   = 5;

    // Bit positions inside the decoder control bundle
    localparam int c_ALUSRC   = 0;
    localparam int c_ALUOP_LO = 1;
    localparam int c_ALUOP_HI = 2;
    localparam int c_REGDST   = 3;
    localparam int c_MEMREAD  = 4;
    localparam int c_MEMWRITE = 5;
    localparam int c_REGWRITE = 6;
    localparam int c_MEMTOREG = 7;

    // ALU operand source selects
    localparam logic [1:0] c_FWD_RF    = 2'b00;
    localparam logic [1:0] c_FWD_EXMEM = 2'b10;
    localparam logic [1:0] c_FWD_MEMWB = 2'b01;

endpackage : ctrl_pipe_pkg
`default_nettype wire

// File: rtl/fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_unit
//  Description : Combinational EX-stage forwarding selector. It compares both
//                ALU source registers of the instruction in EX against the
//                destinations of the two older in-flight instructions.
//  Ports       : i_idex_rs/i_idex_rt        - source registers of EX instr
//                i_exmem_regwrite/i_exmem_dst - writer one stage ahead
//                i_memwb_regwrite/i_memwb_dst - writer two stages ahead
//                o_fwd_a/o_fwd_b            - operand A/B source select
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_unit
    import ctrl_pipe_pkg::*;
#(
    parameter int RA_W = c_RA_W
) (
    input  logic [RA_W-1:0] i_idex_rs,
    input  logic [RA_W-1:0] i_idex_rt,
    input  logic            i_exmem_regwrite,
    input  logic [RA_W-1:0] i_exmem_dst,
    input  logic            i_memwb_regwrite,
    input  logic [RA_W-1:0] i_memwb_dst,
    output logic [1:0]      o_fwd_a,
    output logic [1:0]      o_fwd_b
);

    // Index 0 is operand A (rs) and index 1 is operand B (rt).
    logic [RA_W-1:0] w_src [2];
    logic [1:0]      w_sel [2];

    assign w_src[0] = i_idex_rs;
    assign w_src[1] = i_idex_rt;

    // $0 never produces a value. Ignoring writers whose destination is zero
    // keeps a write to $0 from shadowing the hard-wired zero.
    logic w_exmem_live;
    logic w_memwb_live;

    assign w_exmem_live = i_exmem_regwrite && (i_exmem_dst != '0);
    assign w_memwb_live = i_memwb_regwrite && (i_memwb_dst != '0);

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_operand
            // The younger result (EX/MEM) wins when both stages target the
            // same register, because it is the architecturally newer value.
            always_comb begin
                w_sel[g] = c_FWD_RF;
                if (w_exmem_live && (i_exmem_dst == w_src[g])) begin
                    w_sel[g] = c_FWD_EXMEM;
                end else if (w_memwb_live && (i_memwb_dst == w_src[g])) begin
                    w_sel[g] = c_FWD_MEMWB;
                end
            end
        end
    endgenerate

    assign o_fwd_a = w_sel[0];
    assign o_fwd_b = w_sel[1];

endmodule : fwd_unit
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pipe
//  Description : Control pipeline. It carries the decoder control bundle and
//                the register addresses through the ID/EX, EX/MEM and MEM/WB
//                registers and fans the fields out to each stage. It also
//                holds the load-use hazard detector (stall plus bubble) and
//                the EX-stage forwarding selector.
//  Ports       : clk_i, rst_i (sync, active-low)
//                ctrl_i, rs_i, rt_i, rd_i   - bundle and addresses from ID
//                flush_i                    - kill the instruction in ID
//                stall_o                    - hold PC and IF/ID (comb)
//                alusrc_o, aluop_o          - EX controls
//                fwd_a_o, fwd_b_o           - EX operand source selects
//                memread_o, memwrite_o      - MEM controls
//                regwrite_o, memtoreg_o, wb_rd_o - WB controls
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int CTRL_W = c_CTRL_W,
    parameter int RA_W   = c_RA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [RA_W-1:0]   rs_i,
    input  logic [RA_W-1:0]   rt_i,
    input  logic [RA_W-1:0]   rd_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              alusrc_o,
    output logic [1:0]        aluop_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              memread_o,
    output logic              memwrite_o,
    output logic              regwrite_o,
    output logic              memtoreg_o,
    output logic [RA_W-1:0]   wb_rd_o
);

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    logic [CTRL_W-1:0] r_idex_ctrl;
    logic [RA_W-1:0]   r_idex_rs;
    logic [RA_W-1:0]   r_idex_rt;
    logic [RA_W-1:0]   r_idex_rd;

    // ------------------------------------------------------------------
    // EX/MEM register. Only the fields that MEM and WB still need are kept.
    // ------------------------------------------------------------------
    logic              r_exmem_memread;
    logic              r_exmem_memwrite;
    logic              r_exmem_regwrite;
    logic              r_exmem_memtoreg;
    logic [RA_W-1:0]   r_exmem_dst;

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    logic              r_memwb_regwrite;
    logic              r_memwb_memtoreg;
    logic [RA_W-1:0]   r_memwb_dst;

    // ------------------------------------------------------------------
    // Load-use hazard detection
    // ------------------------------------------------------------------
    // A load in EX cannot supply its data to the instruction now in ID in
    // time. That case needs one bubble, after which the load sits in MEM/WB
    // and reaches the dependent instruction through MEM/WB forwarding.
    logic w_hazard;
    logic w_bubble;
    logic w_idex_dst_match;

    assign w_idex_dst_match = (r_idex_rt == rs_i) || (r_idex_rt == rt_i);

    assign w_hazard = r_idex_ctrl[c_MEMREAD]
                   && (r_idex_rt != '0)
                   && w_idex_dst_match;

    // A flush already discards the ID instruction, so holding IF/ID would
    // only keep a dead instruction alive. The bubble is still inserted.
    assign stall_o  = w_hazard && !flush_i;
    assign w_bubble = w_hazard || flush_i;

    // Destination select for the instruction leaving EX
    logic [RA_W-1:0] w_ex_dst;

    assign w_ex_dst = r_idex_ctrl[c_REGDST] ? r_idex_rd : r_idex_rt;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_idex_ctrl      <= '0;
            r_idex_rs        <= '0;
            r_idex_rt        <= '0;
            r_idex_rd        <= '0;
            r_exmem_memread  <= 1'b0;
            r_exmem_memwrite <= 1'b0;
            r_exmem_regwrite <= 1'b0;
            r_exmem_memtoreg <= 1'b0;
            r_exmem_dst      <= '0;
            r_memwb_regwrite <= 1'b0;
            r_memwb_memtoreg <= 1'b0;
            r_memwb_dst      <= '0;
        end else begin
            // ID/EX: a bubble zeroes only the control bits. The addresses
            // still load, and they are inert without control behind them.
            r_idex_ctrl <= w_bubble ? '0 : ctrl_i;
            r_idex_rs   <= rs_i;
            r_idex_rt   <= rt_i;
            r_idex_rd   <= rd_i;

            // EX/MEM always advances
            r_exmem_memread  <= r_idex_ctrl[c_MEMREAD];
            r_exmem_memwrite <= r_idex_ctrl[c_MEMWRITE];
            r_exmem_regwrite <= r_idex_ctrl[c_REGWRITE];
            r_exmem_memtoreg <= r_idex_ctrl[c_MEMTOREG];
            r_exmem_dst      <= w_ex_dst;

            // MEM/WB always advances
            r_memwb_regwrite <= r_exmem_regwrite;
            r_memwb_memtoreg <= r_exmem_memtoreg;
            r_memwb_dst      <= r_exmem_dst;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding selector
    // ------------------------------------------------------------------
    fwd_unit #(
        .RA_W (RA_W)
    ) u_fwd_unit (
        .i_idex_rs        (r_idex_rs),
        .i_idex_rt        (r_idex_rt),
        .i_exmem_regwrite (r_exmem_regwrite),
        .i_exmem_dst      (r_exmem_dst),
        .i_memwb_regwrite (r_memwb_regwrite),
        .i_memwb_dst      (r_memwb_dst),
        .o_fwd_a          (fwd_a_o),
        .o_fwd_b          (fwd_b_o)
    );

    // ------------------------------------------------------------------
    // Stage fan-out
    // ------------------------------------------------------------------
    assign alusrc_o   = r_idex_ctrl[c_ALUSRC];
    assign aluop_o    = r_idex_ctrl[c_ALUOP_HI:c_ALUOP_LO];
    assign memread_o  = r_exmem_memread;
    assign memwrite_o = r_exmem_memwrite;
    assign regwrite_o = r_memwb_regwrite;
    assign memtoreg_o = r_memwb_memtoreg;
    assign wb_rd_o    = r_memwb_dst;

endmodule : ctrl_pipe
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_pipe
//  Description : Self-checking bench for ctrl_pipe. It runs directed
//                scenarios followed by random instruction streams. Each cycle
//                the outputs are compared against a reference model that
//                tracks whole instructions moving through EX, MEM and WB.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] ctrl_i;
    logic [4:0] rs_i, rt_i, rd_i;
    logic       flush_i;
    logic       stall_o, alusrc_o, memread_o, memwrite_o, regwrite_o, memtoreg_o;
    logic [1:0] aluop_o, fwd_a_o, fwd_b_o;
    logic [4:0] wb_rd_o;

    always #5 clk_i = ~clk_i;

    ctrl_pipe #(.CTRL_W(8), .RA_W(5)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ctrl_i     (ctrl_i),
        .rs_i       (rs_i),
        .rt_i       (rt_i),
        .rd_i       (rd_i),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .alusrc_o   (alusrc_o),
        .aluop_o    (aluop_o),
        .fwd_a_o    (fwd_a_o),
        .fwd_b_o    (fwd_b_o),
        .memread_o  (memread_o),
        .memwrite_o (memwrite_o),
        .regwrite_o (regwrite_o),
        .memtoreg_o (memtoreg_o),
        .wb_rd_o    (wb_rd_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. It keeps whole instructions: slot 0 is in EX,
    // slot 1 in MEM and slot 2 in WB. Control bits are the decoder layout.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [7:0] ctrl;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } m_instr_t;

    m_instr_t m_pipe [3];
    bit       m_valid = 1'b0;

    function automatic logic [4:0] m_dst(input m_instr_t x);
        return x.ctrl[3] ? x.rd : x.rt;
    endfunction

    function automatic bit m_writes(input m_instr_t x, input logic [4:0] r);
        return x.ctrl[6] && (m_dst(x) != 0) && (m_dst(x) == r);
    endfunction

    function automatic bit m_hazard(input logic [4:0] s, input logic [4:0] t);
        return m_pipe[0].ctrl[4] && (m_pipe[0].rt != 0)
            && ((m_pipe[0].rt == s) || (m_pipe[0].rt == t));
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] r);
        if (m_writes(m_pipe[1], r)) return 2'b10;
        if (m_writes(m_pipe[2], r)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_stall();
        return m_hazard(rs_i, rt_i) && !flush_i;
    endfunction

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        m_instr_t nx;
        if (!rst_i) begin
            for (int i = 0; i < 3; i++) m_pipe[i] = '0;
            m_valid = 1'b1;
        end else begin
            nx.ctrl = (flush_i || m_hazard(rs_i, rt_i)) ? 8'h00 : ctrl_i;
            nx.rs = rs_i;
            nx.rt = rt_i;
            nx.rd = rd_i;
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = nx;
        end
    endtask

    task automatic compare_all();
        check_value("stall",    {7'd0, stall_o},    {7'd0, m_stall()});
        check_value("alusrc",   {7'd0, alusrc_o},   {7'd0, m_pipe[0].ctrl[0]});
        check_value("aluop",    {6'd0, aluop_o},    {6'd0, m_pipe[0].ctrl[2:1]});
        check_value("fwd_a",    {6'd0, fwd_a_o},    {6'd0, m_fwd(m_pipe[0].rs)});
        check_value("fwd_b",    {6'd0, fwd_b_o},    {6'd0, m_fwd(m_pipe[0].rt)});
        check_value("memread",  {7'd0, memread_o},  {7'd0, m_pipe[1].ctrl[4]});
        check_value("memwrite", {7'd0, memwrite_o}, {7'd0, m_pipe[1].ctrl[5]});
        check_value("regwrite", {7'd0, regwrite_o}, {7'd0, m_pipe[2].ctrl[6]});
        check_value("memtoreg", {7'd0, memtoreg_o}, {7'd0, m_pipe[2].ctrl[7]});
        check_value("wb_rd",    {3'd0, wb_rd_o},    {3'd0, m_pipe[2].ctrl[6] ? m_dst(m_pipe[2]) : wb_rd_o});
    endtask

    // Drive one cycle of inputs, check against the model, then take the edge.
    task automatic step(input logic r, input logic [7:0] c, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d, input logic f);
        rst_i = r; ctrl_i = c; rs_i = s; rt_i = t; rd_i = d; flush_i = f;
        #2;
        if (m_valid) compare_all();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic [7:0] c, input logic [4:0] s,
                         input logic [4:0] t, input logic [4:0] d, input logic f);
        rst_i = 1'b1; ctrl_i = c; rs_i = s; rt_i = t; rd_i = d; flush_i = f;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    // Realistic bundles: nop, R-type, lw, sw (RegDst set as a don't-care),
    // beq, addi
    logic [7:0] bundles [6] = '{8'h00, 8'h4E, 8'hD3, 8'h29, 8'h02, 8'h41};

    initial begin
        logic [7:0] c;
        logic [4:0] s, t, d;
        logic       f, r;

        rst_i = 1'b0; ctrl_i = '0; rs_i = '0; rt_i = '0; rd_i = '0; flush_i = 1'b0;
        @(posedge clk_i); #1;
        step(1'b0, 8'hFF, 5'd7, 5'd7, 5'd7, 1'b0);
        // Reset state
        check_value("rst_regwrite", {7'd0, regwrite_o}, 8'd0);
        check_value("rst_aluop",    {6'd0, aluop_o},    8'd0);
        check_value("rst_fwd_a",    {6'd0, fwd_a_o},    8'd0);
        check_value("rst_wb_rd",    {3'd0, wb_rd_o},    8'd0);

        // 1. R-type through all stages
        step(1'b1, 8'h4E, 5'd1, 5'd2, 5'd3, 1'b0);
        check_value("t1_aluop",  {6'd0, aluop_o},  8'h03);
        check_value("t1_alusrc", {7'd0, alusrc_o}, 8'h00);
        step(1'b1, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        check_value("t1_regwrite", {7'd0, regwrite_o}, 8'h01);
        check_value("t1_memtoreg", {7'd0, memtoreg_o}, 8'h00);
        check_value("t1_wb_rd",    {3'd0, wb_rd_o},    8'h03);

        // 2. lw followed by a dependent add
        drain();
        step(1'b1, 8'hD3, 5'd0, 5'd4, 5'd0, 1'b0);
        drive(8'h4E, 5'd4, 5'd6, 5'd7, 1'b0);
        check_value("t2_stall_on", {7'd0, stall_o}, 8'h01);
        step(1'b1, 8'h4E, 5'd4, 5'd6, 5'd7, 1'b0);
        check_value("t2_bubble_aluop",  {6'd0, aluop_o},  8'h00);
        check_value("t2_bubble_alusrc", {7'd0, alusrc_o}, 8'h00);
        drive(8'h4E, 5'd4, 5'd6, 5'd7, 1'b0);
        check_value("t2_stall_off", {7'd0, stall_o}, 8'h00);
        step(1'b1, 8'h4E, 5'd4, 5'd6, 5'd7, 1'b0);
        check_value("t2_fwd_a", {6'd0, fwd_a_o}, 8'h01);
        check_value("t2_fwd_b", {6'd0, fwd_b_o}, 8'h00);

        // 3. Back-to-back dependency
        drain();
        step(1'b1, 8'h41, 5'd0, 5'd5, 5'd0, 1'b0);
        step(1'b1, 8'h4E, 5'd5, 5'd5, 5'd8, 1'b0);
        check_value("t3_fwd_a", {6'd0, fwd_a_o}, 8'h02);
        check_value("t3_fwd_b", {6'd0, fwd_b_o}, 8'h02);

        // 4. Both older stages write $5; the younger one wins
        drain();
        step(1'b1, 8'h41, 5'd0, 5'd5, 5'd0, 1'b0);
        step(1'b1, 8'h41, 5'd0, 5'd5, 5'd0, 1'b0);
        step(1'b1, 8'h4E, 5'd5, 5'd9, 5'd10, 1'b0);
        check_value("t4_fwd_a", {6'd0, fwd_a_o}, 8'h02);

        // 5. Flush coinciding with a load-use hazard
        drain();
        step(1'b1, 8'hD3, 5'd0, 5'd4, 5'd0, 1'b0);
        drive(8'h4E, 5'd4, 5'd1, 5'd2, 1'b1);
        check_value("t5_stall", {7'd0, stall_o}, 8'h00);
        step(1'b1, 8'h4E, 5'd4, 5'd1, 5'd2, 1'b1);
        check_value("t5_ex_alusrc", {7'd0, alusrc_o}, 8'h00);
        check_value("t5_ex_aluop",  {6'd0, aluop_o},  8'h00);

        // 6. Reset while a load is in MEM
        drain();
        step(1'b1, 8'hD3, 5'd0, 5'd4, 5'd0, 1'b0);
        step(1'b1, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        check_value("t6_memread_pre", {7'd0, memread_o}, 8'h01);
        step(1'b0, 8'h4E, 5'd1, 5'd2, 5'd3, 1'b0);
        check_value("t6_memread",  {7'd0, memread_o},  8'h00);
        check_value("t6_regwrite", {7'd0, regwrite_o}, 8'h00);
        check_value("t6_aluop",    {6'd0, aluop_o},    8'h00);
        step(1'b1, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        check_value("t6_no_wb", {7'd0, regwrite_o}, 8'h00);

        // 7. $0 is never a hazard or forwarding source
        drain();
        step(1'b1, 8'h41, 5'd0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 8'hD3, 5'd0, 5'd0, 5'd0, 1'b0);
        drive(8'h4E, 5'd0, 5'd0, 5'd1, 1'b0);
        check_value("t7_stall", {7'd0, stall_o}, 8'h00);
        step(1'b1, 8'h4E, 5'd0, 5'd0, 5'd1, 1'b0);
        check_value("t7_fwd_a", {6'd0, fwd_a_o}, 8'h00);

        // Random streams. While stalled, hold the ID inputs as IF/ID would.
        c = 8'h00; s = '0; t = '0; d = '0;
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            f = ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0;
            rst_i = 1'b1; ctrl_i = c; rs_i = s; rt_i = t; flush_i = 1'b0;
            if (!m_stall() || f || !r) begin
                c = ($urandom_range(0, 9) == 0) ? 8'($urandom) : bundles[$urandom_range(0, 5)];
                s = 5'($urandom_range(0, 7));
                t = 5'($urandom_range(0, 7));
                d = 5'($urandom_range(0, 7));
            end
            step(r, c, s, t, d, f);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard bound on simulated time so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule : tb_ctrl_pipe
`default_nettype wire
